// File: rtl/rf_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module  : rf_operand_fetch
// Brief   : Register-file read client between decode and execute. Issues the
//           registered rs1/rs2 reads, covers the 1-cycle read latency, keeps
//           held operands coherent with writeback, and presents complete
//           operands through a one-entry valid/ready output stage.
// Revision: 1.0 - initial release
// ============================================================================
module rf_operand_fetch #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5,
    parameter int TagWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 flush_i,
    input  logic                 dec_valid_i,
    output logic                 dec_ready_o,
    input  logic                 dec_rs1_used_i,
    input  logic [AddrWidth-1:0] dec_rs1_addr_i,
    input  logic                 dec_rs2_used_i,
    input  logic [AddrWidth-1:0] dec_rs2_addr_i,
    input  logic [TagWidth-1:0]  dec_tag_i,
    output logic                 rf_rs1_valid_o,
    output logic [AddrWidth-1:0] rf_rs1_addr_o,
    input  logic [DataWidth-1:0] rf_rs1_data_i,
    output logic                 rf_rs2_valid_o,
    output logic [AddrWidth-1:0] rf_rs2_addr_o,
    input  logic [DataWidth-1:0] rf_rs2_data_i,
    input  logic                 wb_valid_i,
    input  logic [AddrWidth-1:0] wb_addr_i,
    input  logic [DataWidth-1:0] wb_data_i,
    output logic                 ex_valid_o,
    input  logic                 ex_ready_i,
    output logic [DataWidth-1:0] ex_rs1_data_o,
    output logic [DataWidth-1:0] ex_rs2_data_o,
    output logic [TagWidth-1:0]  ex_tag_o
);

    logic                ex_valid_q;
    logic [TagWidth-1:0] tag_q;
    logic                w_accept;
    logic                w_stall;
    logic                w_leave;

    // Per-source request view (index 0 = rs1, 1 = rs2).
    logic [1:0]                 w_req_used;
    logic [AddrWidth-1:0]       w_req_addr [2];
    logic [DataWidth-1:0]       w_rf_data  [2];
    logic [DataWidth-1:0]       w_oper     [2];

    // Reset gating keeps the block from advertising ready while held in reset.
    assign dec_ready_o = !reset_i && !flush_i && (!ex_valid_q || ex_ready_i);
    assign w_accept    = dec_valid_i && dec_ready_o;
    assign w_leave     = ex_valid_q && ex_ready_i;
    assign w_stall     = ex_valid_q && !ex_ready_i;

    // x0 and unused sources never touch the register file.
    assign w_req_used[0] = dec_rs1_used_i && (dec_rs1_addr_i != '0);
    assign w_req_used[1] = dec_rs2_used_i && (dec_rs2_addr_i != '0);
    assign w_req_addr[0] = dec_rs1_addr_i;
    assign w_req_addr[1] = dec_rs2_addr_i;
    assign w_rf_data[0]  = rf_rs1_data_i;
    assign w_rf_data[1]  = rf_rs2_data_i;

    assign rf_rs1_valid_o = w_accept && w_req_used[0];
    assign rf_rs2_valid_o = w_accept && w_req_used[1];
    assign rf_rs1_addr_o  = dec_rs1_addr_i;
    assign rf_rs2_addr_o  = dec_rs2_addr_i;

    assign ex_valid_o    = ex_valid_q;
    assign ex_tag_o      = tag_q;
    assign ex_rs1_data_o = w_oper[0];
    assign ex_rs2_data_o = w_oper[1];

    // Output-stage occupancy and payload: flush wins, then accept, then drain.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ex_valid_q <= 1'b0;
            tag_q      <= '0;
        end else if (flush_i) begin
            ex_valid_q <= 1'b0;
        end else if (w_accept) begin
            ex_valid_q <= 1'b1;
            tag_q      <= dec_tag_i;
        end else if (w_leave) begin
            ex_valid_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_src
        logic                 used_q;
        logic                 first_q;
        logic                 byp_valid_q;
        logic [AddrWidth-1:0] addr_q;
        logic [DataWidth-1:0] byp_data_q;
        logic [DataWidth-1:0] hold_q;
        logic                 w_hit;

        // A writeback to the held register while the entry stays put.
        assign w_hit = used_q && wb_valid_i && (wb_addr_i == addr_q);

        // First valid cycle: rf read data unless a same-cycle write was
        // captured in the bypass; afterwards the coherent hold register.
        assign w_oper[i] = !used_q     ? '0 :
                           first_q     ? (byp_valid_q ? byp_data_q : w_rf_data[i]) :
                                         hold_q;

        // Capture on accept, fold writebacks into the hold register on stall.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                used_q      <= 1'b0;
                first_q     <= 1'b0;
                byp_valid_q <= 1'b0;
                addr_q      <= '0;
                byp_data_q  <= '0;
                hold_q      <= '0;
            end else if (flush_i) begin
                used_q      <= 1'b0;
                first_q     <= 1'b0;
                byp_valid_q <= 1'b0;
            end else if (w_accept) begin
                used_q      <= w_req_used[i];
                addr_q      <= w_req_addr[i];
                first_q     <= 1'b1;
                byp_valid_q <= wb_valid_i && (wb_addr_i == w_req_addr[i]);
                byp_data_q  <= wb_data_i;
            end else if (w_stall) begin
                first_q     <= 1'b0;
                byp_valid_q <= 1'b0;
                hold_q      <= w_hit ? wb_data_i : w_oper[i];
            end else if (w_leave) begin
                used_q      <= 1'b0;
                first_q     <= 1'b0;
                byp_valid_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_rf_operand_fetch
// Brief   : Directed self-checking bench for rf_operand_fetch with a small
//           behavioural register file (registered reads, x0 hardwired).
// Revision: 1.0 - initial release
// ============================================================================
module tb_rf_operand_fetch;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        dec_valid_i;
    logic        dec_ready_o;
    logic        dec_rs1_used_i;
    logic [4:0]  dec_rs1_addr_i;
    logic        dec_rs2_used_i;
    logic [4:0]  dec_rs2_addr_i;
    logic [31:0] dec_tag_i;
    logic        rf_rs1_valid_o;
    logic [4:0]  rf_rs1_addr_o;
    logic [31:0] rf_rs1_data_i;
    logic        rf_rs2_valid_o;
    logic [4:0]  rf_rs2_addr_o;
    logic [31:0] rf_rs2_data_i;
    logic        wb_valid_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [31:0] ex_rs1_data_o;
    logic [31:0] ex_rs2_data_o;
    logic [31:0] ex_tag_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] regs [32];

    rf_operand_fetch dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .flush_i        (flush_i),
        .dec_valid_i    (dec_valid_i),
        .dec_ready_o    (dec_ready_o),
        .dec_rs1_used_i (dec_rs1_used_i),
        .dec_rs1_addr_i (dec_rs1_addr_i),
        .dec_rs2_used_i (dec_rs2_used_i),
        .dec_rs2_addr_i (dec_rs2_addr_i),
        .dec_tag_i      (dec_tag_i),
        .rf_rs1_valid_o (rf_rs1_valid_o),
        .rf_rs1_addr_o  (rf_rs1_addr_o),
        .rf_rs1_data_i  (rf_rs1_data_i),
        .rf_rs2_valid_o (rf_rs2_valid_o),
        .rf_rs2_addr_o  (rf_rs2_addr_o),
        .rf_rs2_data_i  (rf_rs2_data_i),
        .wb_valid_i     (wb_valid_i),
        .wb_addr_i      (wb_addr_i),
        .wb_data_i      (wb_data_i),
        .ex_valid_o     (ex_valid_o),
        .ex_ready_i     (ex_ready_i),
        .ex_rs1_data_o  (ex_rs1_data_o),
        .ex_rs2_data_o  (ex_rs2_data_o),
        .ex_tag_o       (ex_tag_o)
    );

    always #5 clk_i = ~clk_i;

    // Register file model: reads return pre-write contents, x0 stays zero.
    always_ff @(posedge clk_i) begin
        if (wb_valid_i && wb_addr_i != 5'd0) regs[wb_addr_i] <= wb_data_i;
        if (rf_rs1_valid_o) rf_rs1_data_i <= regs[rf_rs1_addr_o];
        if (rf_rs2_valid_o) rf_rs2_data_i <= regs[rf_rs2_addr_o];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic u1, input logic [4:0] a1, input logic u2,
                       input logic [4:0] a2, input logic [31:0] tag);
        dec_valid_i    = 1'b1;
        dec_rs1_used_i = u1;
        dec_rs1_addr_i = a1;
        dec_rs2_used_i = u2;
        dec_rs2_addr_i = a2;
        dec_tag_i      = tag;
    endtask

    task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb_valid_i = v;
        wb_addr_i  = a;
        wb_data_i  = d;
    endtask

    logic [31:0] exp1 [5];

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        rf_rs1_data_i = 32'h0;
        rf_rs2_data_i = 32'h0;
        reset_i = 1'b1; flush_i = 1'b0; ex_ready_i = 1'b0;
        dec_valid_i = 1'b0; req(1'b0, 5'd0, 1'b0, 5'd0, 32'h0); dec_valid_i = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        #1;
        chk("reset_ex_valid", {31'h0, ex_valid_o}, 32'h0);
        chk("reset_dec_ready", {31'h0, dec_ready_o}, 32'h0);
        chk("reset_tag", ex_tag_o, 32'h0);
        chk("reset_rs1", ex_rs1_data_o, 32'h0);
        tick(); tick();
        reset_i = 1'b0;

        // 1: preload x5, then read rs1=5 with rs2=x0
        wb(1'b1, 5'd5, 32'h0000_1234);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        req(1'b1, 5'd5, 1'b1, 5'd0, 32'hA1);
        ex_ready_i = 1'b1;
        #1;
        chk("t1_dec_ready", {31'h0, dec_ready_o}, 32'h1);
        chk("t1_rf_rs1_valid", {31'h0, rf_rs1_valid_o}, 32'h1);
        chk("t1_rf_rs2_valid", {31'h0, rf_rs2_valid_o}, 32'h0);
        tick();
        dec_valid_i = 1'b0;
        chk("t1_ex_valid", {31'h0, ex_valid_o}, 32'h1);
        chk("t1_rs1", ex_rs1_data_o, 32'h0000_1234);
        chk("t1_rs2", ex_rs2_data_o, 32'h0);
        chk("t1_tag", ex_tag_o, 32'hA1);
        tick();
        chk("t1_drain", {31'h0, ex_valid_o}, 32'h0);

        // 2: write in the accept cycle must be bypassed
        wb(1'b1, 5'd7, 32'h0000_0011);
        tick();
        req(1'b1, 5'd7, 1'b0, 5'd0, 32'hA2);
        wb(1'b1, 5'd7, 32'hDEAD_BEEF);
        tick();
        dec_valid_i = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        chk("t2_ex_valid", {31'h0, ex_valid_o}, 32'h1);
        chk("t2_rs1_bypass", ex_rs1_data_o, 32'hDEAD_BEEF);
        tick();

        // 3: stall with a write to the held register in stall cycle 2
        ex_ready_i = 1'b0;
        req(1'b0, 5'd0, 1'b1, 5'd7, 32'hA3);
        tick();
        req(1'b1, 5'd7, 1'b1, 5'd7, 32'hEE);
        #1;
        chk("t3_c1_rs2", ex_rs2_data_o, 32'hDEAD_BEEF);
        chk("t3_c1_dec_ready", {31'h0, dec_ready_o}, 32'h0);
        chk("t3_c1_rf_valid", {30'h0, rf_rs1_valid_o, rf_rs2_valid_o}, 32'h0);
        tick();
        chk("t3_c2_rs2", ex_rs2_data_o, 32'hDEAD_BEEF);
        wb(1'b1, 5'd7, 32'h0000_A5A5);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("t3_c3_rs2", ex_rs2_data_o, 32'h0000_A5A5);
        chk("t3_c3_ex_valid", {31'h0, ex_valid_o}, 32'h1);
        chk("t3_c3_rf_valid", {30'h0, rf_rs1_valid_o, rf_rs2_valid_o}, 32'h0);
        tick();
        chk("t3_c4_rs2", ex_rs2_data_o, 32'h0000_A5A5);
        chk("t3_c4_tag", ex_tag_o, 32'hA3);
        chk("t3_c4_rs1_unused", ex_rs1_data_o, 32'h0);
        dec_valid_i = 1'b0;
        ex_ready_i  = 1'b1;
        tick();
        chk("t3_drain", {31'h0, ex_valid_o}, 32'h0);

        // 4: four back-to-back requests, rs1 alternates x5/x7, rs2 = x5
        exp1[1] = 32'h0000_1234; exp1[2] = 32'h0000_A5A5;
        exp1[3] = 32'h0000_1234; exp1[4] = 32'h0000_A5A5;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) req(1'b1, (k % 2 == 1) ? 5'd5 : 5'd7, 1'b1, 5'd5, k);
            else        dec_valid_i = 1'b0;
            tick();
            chk($sformatf("t4_valid_%0d", k), {31'h0, ex_valid_o}, 32'h1);
            chk($sformatf("t4_tag_%0d", k), ex_tag_o, k);
            chk($sformatf("t4_rs1_%0d", k), ex_rs1_data_o, exp1[k]);
            chk($sformatf("t4_rs2_%0d", k), ex_rs2_data_o, 32'h0000_1234);
            if (k == 4) break;
        end
        dec_valid_i = 1'b0;
        tick();
        chk("t4_drain", {31'h0, ex_valid_o}, 32'h0);

        // 5: writes to x0 never reach an rs1=x0 operand
        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        ex_ready_i = 1'b0;
        req(1'b1, 5'd0, 1'b0, 5'd0, 32'hA5);
        #1;
        chk("t5_rf_rs1_valid", {31'h0, rf_rs1_valid_o}, 32'h0);
        tick();
        dec_valid_i = 1'b0;
        chk("t5_c1_rs1", ex_rs1_data_o, 32'h0);
        tick();
        chk("t5_c2_rs1", ex_rs1_data_o, 32'h0);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("t5_c3_rs1", ex_rs1_data_o, 32'h0);
        chk("t5_c3_valid", {31'h0, ex_valid_o}, 32'h1);

        // 6a: flush while stalled with a pending decode request
        flush_i = 1'b1;
        req(1'b1, 5'd5, 1'b0, 5'd0, 32'hA6);
        #1;
        chk("t6_flush_dec_ready", {31'h0, dec_ready_o}, 32'h0);
        chk("t6_flush_rf_valid", {31'h0, rf_rs1_valid_o}, 32'h0);
        tick();
        flush_i = 1'b0;
        dec_valid_i = 1'b0;
        chk("t6_flush_ex_valid", {31'h0, ex_valid_o}, 32'h0);

        // 6b: asynchronous reset mid-cycle with an entry held
        req(1'b1, 5'd5, 1'b0, 5'd0, 32'hA7);
        tick();
        dec_valid_i = 1'b0;
        chk("t6_entry_valid", {31'h0, ex_valid_o}, 32'h1);
        chk("t6_entry_rs1", ex_rs1_data_o, 32'h0000_1234);
        #2;
        reset_i = 1'b1;
        #1;
        chk("t6_async_ex_valid", {31'h0, ex_valid_o}, 32'h0);
        chk("t6_async_tag", ex_tag_o, 32'h0);
        chk("t6_async_rs1", ex_rs1_data_o, 32'h0);
        chk("t6_async_dec_ready", {31'h0, dec_ready_o}, 32'h0);
        tick();
        reset_i = 1'b0;
        #1;
        chk("t6_after_reset_valid", {31'h0, ex_valid_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
